// File: rtl/rv32_wb_pkg.sv
// Shared types for the register-file writeback path: widths, queued MDU result entry, arbiter FSM states.
package rv32_wb_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

  typedef enum logic {
    WB_NORMAL,
    WB_FORCE
  } wb_state_t;
endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of MDU writeback entries; any entry whose rd matches squash_rd is invalidated in place.
module wb_fifo
  import rv32_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic                  push,
  input  wb_entry_t             push_entry,
  input  logic                  pop,
  input  logic                  squash_en,
  input  logic [REG_ADDR_W-1:0] squash_rd,
  output wb_entry_t             head,
  output logic                  empty,
  output logic                  full,
  output logic [NUM_REGS-1:0]   valid_mask
);
  localparam int PTR_W = $clog2(DEPTH);

  wb_entry_t        slot_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;

  assign head  = slot_reg[rd_ptr_reg];
  assign empty = (count_reg == '0);
  assign full  = (count_reg == (PTR_W+1)'(DEPTH));

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      for (int s = 0; s < DEPTH; s++) slot_reg[s] <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
      // Popped slots drop their valid bit so the pending mask only reflects live entries.
      for (int s = 0; s < DEPTH; s++) begin
        if (push && wr_ptr_reg == PTR_W'(s))
          slot_reg[s] <= push_entry;
        else if ((pop && rd_ptr_reg == PTR_W'(s)) ||
                 (squash_en && slot_reg[s].rd == squash_rd))
          slot_reg[s].valid <= 1'b0;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_mask
      always_comb begin
        valid_mask[gi] = 1'b0;
        for (int s = 0; s < DEPTH; s++)
          if (slot_reg[s].valid && slot_reg[s].rd == REG_ADDR_W'(gi))
            valid_mask[gi] = 1'b1;
      end
    end
  endgenerate
endmodule

// File: rtl/reg_writeback_arbiter.sv
// Merges ALU and queued MDU results onto the single register-file write port with bounded MDU starvation.
// Optional PENDING hazard mask port is built only when WB_PENDING_MASK_EN is defined.
module reg_writeback_arbiter
  import rv32_wb_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic                  ALU_VALID,
  input  logic [REG_ADDR_W-1:0] ALU_RD,
  input  logic [XLEN-1:0]       ALU_DATA,
  input  logic                  MDU_VALID,
  output logic                  MDU_READY,
  input  logic [REG_ADDR_W-1:0] MDU_RD,
  input  logic [XLEN-1:0]       MDU_DATA,
  output logic                  ALU_STALL,
  output logic                  WRITE,
  output logic [REG_ADDR_W-1:0] INADDRESS,
  output logic [XLEN-1:0]       IN
`ifdef WB_PENDING_MASK_EN
  ,
  output logic [NUM_REGS-1:0]   PENDING
`endif
);
  localparam int CNT_W = $clog2(STARVE_LIMIT) + 1;

  wb_entry_t             head;
  wb_entry_t             push_entry;
  logic                  fifo_empty, fifo_full;
  logic [NUM_REGS-1:0]   valid_mask;
  logic                  alu_win, push, pop, drain_write, any_valid, force_go;
  wb_state_t             state_reg, state_next;
  logic [CNT_W-1:0]      starve_reg, starve_next;
  logic                  write_reg;
  logic [REG_ADDR_W-1:0] addr_reg;
  logic [XLEN-1:0]       data_reg;

  assign alu_win   = ALU_VALID && (ALU_RD != '0);
  assign MDU_READY = !fifo_full;
  assign push      = MDU_VALID && !fifo_full && (MDU_RD != '0);
  // An MDU result racing a younger ALU write to the same rd is stale on arrival.
  assign push_entry = '{valid: !(alu_win && MDU_RD == ALU_RD), rd: MDU_RD, data: MDU_DATA};
  // Squashed heads need no write port, so they drain even while the ALU owns it.
  assign pop         = !fifo_empty && (!alu_win || !head.valid);
  assign drain_write = pop && head.valid;
  assign any_valid   = |valid_mask;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLOCK      (CLOCK),
    .RESET      (RESET),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .squash_en  (alu_win),
    .squash_rd  (ALU_RD),
    .head       (head),
    .empty      (fifo_empty),
    .full       (fifo_full),
    .valid_mask (valid_mask)
  );

  always_comb begin
    state_next  = state_reg;
    starve_next = starve_reg;
    force_go    = 1'b0;
    case (state_reg)
      WB_NORMAL: begin
        if (pop || fifo_empty) begin
          starve_next = '0;
        end else if (alu_win && any_valid) begin
          if (starve_reg == CNT_W'(STARVE_LIMIT - 1)) begin
            force_go    = 1'b1;
            starve_next = '0;
            state_next  = WB_FORCE;
          end else begin
            starve_next = starve_reg + 1'b1;
          end
        end
      end
      WB_FORCE: begin
        starve_next = '0;
        state_next  = WB_NORMAL;
      end
      default: begin
        starve_next = '0;
        state_next  = WB_NORMAL;
      end
    endcase
  end

  assign ALU_STALL = force_go;

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_reg  <= WB_NORMAL;
      starve_reg <= '0;
      write_reg  <= 1'b0;
      addr_reg   <= '0;
      data_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      starve_reg <= starve_next;
      write_reg  <= alu_win || drain_write;
      if (alu_win) begin
        addr_reg <= ALU_RD;
        data_reg <= ALU_DATA;
      end else if (drain_write) begin
        addr_reg <= head.rd;
        data_reg <= head.data;
      end
    end
  end

  assign WRITE     = write_reg;
  assign INADDRESS = addr_reg;
  assign IN        = data_reg;

`ifdef WB_PENDING_MASK_EN
  assign PENDING = valid_mask;
`endif

  // The pipeline must honour the stall: no ALU writeback in the forced-drain cycle.
  a_force_no_alu: assert property (@(posedge CLOCK) disable iff (!RESET)
    (state_reg == WB_FORCE) |-> !ALU_VALID);
endmodule
